// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request/response bundle between the MEM stage and data_mem_lsu
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed RV32I data memory with sized loads/stores and wait states
// Optional DMEM_INIT_CLEAR_EN: zero-fill sweep of the whole array after every reset.
module data_mem_lsu #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_lsu_if.slave bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;
  localparam state_t RST_STATE = ST_INIT;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic               fire;
  logic               op_we;
  logic [2:0]         op_f3;
  logic [ADDR_W-1:0]  op_addr;
  logic [31:0]        op_wdata;
  logic [IDX_W-1:0]   op_idx;
  logic [1:0]         op_lane;
  logic               op_err;
  logic [3:0]         op_be;
  logic [31:0]        op_wword;
  logic [31:0]        op_load;
  logic [31:0]        rd_word;
  logic [31:0]        rd_shift;
  logic               unused_addr_hi;

  assign bus.req_ready   = (state_q == ST_IDLE) && !reset;
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign accept          = bus.req_valid && bus.req_ready;
  assign unused_addr_hi  = ^bus.req_addr[31:ADDR_W];

`ifdef DMEM_INIT_CLEAR_EN
  logic [IDX_W-1:0] init_q, init_d;
  assign bus.init_busy = (state_q == ST_INIT) && !reset;
`else
  assign bus.init_busy = 1'b0;
`endif

  // With no wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    op_we    = we_q;
    op_f3    = f3_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    if (WAIT_CYCLES == 0) begin
      op_we    = bus.req_we;
      op_f3    = bus.req_funct3;
      op_addr  = bus.req_addr[ADDR_W-1:0];
      op_wdata = bus.req_wdata;
    end
  end

  always_comb begin
    op_idx  = op_addr[ADDR_W-1:2];
    op_lane = op_addr[1:0];
    if (op_we) op_err = (op_f3 > 3'd2);
    else       op_err = (op_f3 == 3'd3) || (op_f3 == 3'd6) || (op_f3 == 3'd7);
    if ((op_f3[1:0] == 2'd1) && op_lane[0])        op_err = 1'b1;
    if ((op_f3[1:0] == 2'd2) && (op_lane != 2'd0)) op_err = 1'b1;

    op_be    = 4'b1111;
    op_wword = op_wdata;
    case (op_f3[1:0])
      2'd0: begin
        op_be    = 4'b0001 << op_lane;
        op_wword = {4{op_wdata[7:0]}};
      end
      2'd1: begin
        op_be    = op_lane[1] ? 4'b1100 : 4'b0011;
        op_wword = {2{op_wdata[15:0]}};
      end
      default: op_be = 4'b1111;
    endcase

    rd_word  = mem[op_idx];
    rd_shift = rd_word >> {op_lane, 3'b000};
    case (op_f3)
      3'd0:    op_load = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    op_load = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    op_load = {24'b0, rd_shift[7:0]};
      3'd5:    op_load = {16'b0, rd_shift[15:0]};
      default: op_load = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
    init_d  = init_q;
`endif
    case (state_q)
`ifdef DMEM_INIT_CLEAR_EN
      ST_INIT: begin
        init_d = init_q + 1'b1;
        if (init_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
`endif
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
      init_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef DMEM_INIT_CLEAR_EN
      init_q  <= init_d;
`endif
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr[ADDR_W-1:0];
        wdata_q <= bus.req_wdata;
      end
      if (fire) begin
        rdata_q <= (op_err || op_we) ? 32'd0 : op_load;
        err_q   <= op_err;
      end
    end
  end

  // Array has no reset; fire and init_busy are both forced low while reset is held.
  always_ff @(posedge clk) begin
`ifdef DMEM_INIT_CLEAR_EN
    if (bus.init_busy) mem[init_q] <= 32'd0;
`endif
    if (fire && op_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wword[8*i +: 8];
      end
    end
  end
endmodule
